// File: rtl/cpu_pkg.sv
// Shared definitions for the 6502-class core: addressing modes and the
// addressing-mode sequencer state set.
package cpu_pkg;

  typedef enum logic [3:0] {
    AM_IMM  = 4'd0,
    AM_ZP   = 4'd1,
    AM_ZPX  = 4'd2,
    AM_ZPY  = 4'd3,
    AM_ABS  = 4'd4,
    AM_ABSX = 4'd5,
    AM_ABSY = 4'd6,
    AM_INX  = 4'd7,
    AM_INY  = 4'd8
  } am_mode_t;

  localparam logic [3:0] AM_LAST = 4'd8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_OP1,
    S_OP2,
    S_IDX,
    S_PTR_LO,
    S_PTR_HI,
    S_FIX,
    S_DONE
  } seq_state_t;

  // Undefined encodings behave as immediate.
  function automatic am_mode_t decode_mode(input logic [3:0] m);
    return (m > AM_LAST) ? AM_IMM : am_mode_t'(m);
  endfunction

endpackage

// File: rtl/addr_mode_seq_idx_add.sv
// Indexed address adder: low byte + index with carry, high byte + carry
// (high byte wraps modulo 2^DATA_W).
module idx_add #(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] lo,
  input  logic [DATA_W-1:0] idx,
  input  logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] sum,
  output logic [DATA_W-1:0] hi_adj,
  output logic              carry
);

  logic [DATA_W:0] full;

  assign full   = {1'b0, lo} + {1'b0, idx};
  assign sum    = full[DATA_W-1:0];
  assign carry  = full[DATA_W];
  assign hi_adj = hi + {{(DATA_W-1){1'b0}}, carry};

endmodule

// File: rtl/addr_mode_seq.sv
// Addressing-mode sequencer: fetches operand/pointer bytes and produces the
// effective address. ADDR_MODE_SEQ_DUMMY_READ_EN drives the uncorrected address during FIX.
module addr_mode_seq
  import cpu_pkg::*;
#(
  parameter int unsigned       DATA_W = 8,
  parameter int unsigned       ADDR_W = 16,
  parameter logic [DATA_W-1:0] ZP_HI  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        mode,
  input  logic              wr,
  input  logic [ADDR_W-1:0] pc,
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  input  logic [DATA_W-1:0] d_in,
  output logic [ADDR_W-1:0] addr,
  output logic              busy,
  output logic              ea_valid,
  output logic [ADDR_W-1:0] ea,
  output logic              page_cross,
  output logic [1:0]        op_len
);

  seq_state_t        state, state_n;
  am_mode_t          mode_r, mode_n;
  logic              wr_r, wr_n;
  logic [ADDR_W-1:0] pc_r, pc_n;
  logic [DATA_W-1:0] x_r, x_n, y_r, y_n;
  logic [DATA_W-1:0] lo_r, lo_n, hi_r, hi_n, ptr_r, ptr_n;
  logic [ADDR_W-1:0] addr_n, ea_n;
  logic              pcross_n;
  logic [1:0]        op_len_n;

  logic [DATA_W-1:0] idx_sel, hi_src, sum, hi_adj, zp_idx, ptr_inc;
  logic              carry;
  logic [1:0]        mode_len;

  assign busy     = (state != S_IDLE);
  assign ea_valid = (state == S_DONE);

  assign idx_sel  = (mode_r == AM_ZPX || mode_r == AM_ABSX) ? x_r : y_r;
  // FIX works from the stored high byte; OP2/PTR_HI add against the byte arriving now.
  assign hi_src   = (state == S_FIX) ? hi_r : d_in;
  assign zp_idx   = d_in + x_r;
  assign ptr_inc  = ptr_r + DATA_W'(1);
  assign mode_len = (mode_r == AM_ABS || mode_r == AM_ABSX || mode_r == AM_ABSY) ? 2'd2 : 2'd1;

  idx_add #(.DATA_W(DATA_W)) u_idx_add (
    .lo     (lo_r),
    .idx    (idx_sel),
    .hi     (hi_src),
    .sum    (sum),
    .hi_adj (hi_adj),
    .carry  (carry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      mode_r     <= AM_IMM;
      wr_r       <= 1'b0;
      pc_r       <= '0;
      x_r        <= '0;
      y_r        <= '0;
      lo_r       <= '0;
      hi_r       <= '0;
      ptr_r      <= '0;
      addr       <= '0;
      ea         <= '0;
      page_cross <= 1'b0;
      op_len     <= '0;
    end else begin
      state      <= state_n;
      mode_r     <= mode_n;
      wr_r       <= wr_n;
      pc_r       <= pc_n;
      x_r        <= x_n;
      y_r        <= y_n;
      lo_r       <= lo_n;
      hi_r       <= hi_n;
      ptr_r      <= ptr_n;
      addr       <= addr_n;
      ea         <= ea_n;
      page_cross <= pcross_n;
      op_len     <= op_len_n;
    end
  end

  always_comb begin
    state_n  = state;
    mode_n   = mode_r;
    wr_n     = wr_r;
    pc_n     = pc_r;
    x_n      = x_r;
    y_n      = y_r;
    lo_n     = lo_r;
    hi_n     = hi_r;
    ptr_n    = ptr_r;
    addr_n   = addr;
    ea_n     = ea;
    pcross_n = page_cross;
    op_len_n = op_len;

    case (state)
      S_IDLE: begin
        if (start) begin
          mode_n = decode_mode(mode);
          wr_n   = wr;
          pc_n   = pc;
          x_n    = x;
          y_n    = y;
          if (decode_mode(mode) == AM_IMM) begin
            ea_n     = pc;
            pcross_n = 1'b0;
            op_len_n = 2'd1;
            state_n  = S_DONE;
          end else begin
            addr_n  = pc;
            state_n = S_OP1;
          end
        end
      end

      S_OP1: begin
        lo_n = d_in;
        case (mode_r)
          AM_ZP: begin
            ea_n     = {ZP_HI, d_in};
            pcross_n = 1'b0;
            op_len_n = 2'd1;
            state_n  = S_DONE;
          end
          AM_ZPX, AM_ZPY: begin
            addr_n  = {ZP_HI, d_in};
            state_n = S_IDX;
          end
          AM_INX: begin
            ptr_n   = zp_idx;
            addr_n  = {ZP_HI, zp_idx};
            state_n = S_PTR_LO;
          end
          AM_INY: begin
            ptr_n   = d_in;
            addr_n  = {ZP_HI, d_in};
            state_n = S_PTR_LO;
          end
          default: begin
            addr_n  = pc_r + ADDR_W'(1);
            state_n = S_OP2;
          end
        endcase
      end

      S_IDX: begin
        ea_n     = {ZP_HI, sum};
        pcross_n = 1'b0;
        op_len_n = 2'd1;
        state_n  = S_DONE;
      end

      S_PTR_LO: begin
        lo_n    = d_in;
        addr_n  = {ZP_HI, ptr_inc};
        state_n = S_PTR_HI;
      end

      S_OP2, S_PTR_HI: begin
        hi_n = d_in;
        if (mode_r == AM_ABS || mode_r == AM_INX) begin
          ea_n     = {d_in, lo_r};
          pcross_n = 1'b0;
          op_len_n = mode_len;
          state_n  = S_DONE;
        end else if (carry || wr_r) begin
`ifdef ADDR_MODE_SEQ_DUMMY_READ_EN
          addr_n  = {d_in, sum};
`endif
          state_n = S_FIX;
        end else begin
          ea_n     = {hi_adj, sum};
          pcross_n = 1'b0;
          op_len_n = mode_len;
          state_n  = S_DONE;
        end
      end

      S_FIX: begin
        ea_n     = {hi_adj, sum};
        pcross_n = carry;
        op_len_n = mode_len;
        state_n  = S_DONE;
      end

      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_addr_mode_seq.sv
// Bench for addr_mode_seq: arithmetic reference model checked every cycle,
// plus literal expectations for the key addressing cases.
module tb_addr_mode_seq;

  logic        clk = 1'b0;
  logic        rst, start, start1, wr;
  logic [3:0]  mode;
  logic [15:0] pc;
  logic [7:0]  x, y, d_in, d_in1;
  logic [15:0] addr, ea, addr1, ea1;
  logic        busy, ea_valid, page_cross, busy1, ea_valid1, page_cross1;
  logic [1:0]  op_len, op_len1;

  logic [7:0]  mem [0:65535];

  always #5 clk = ~clk;

  assign d_in  = mem[addr];
  assign d_in1 = mem[addr1];

  addr_mode_seq #(.DATA_W(8), .ADDR_W(16), .ZP_HI(8'h00)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .wr(wr), .pc(pc),
    .x(x), .y(y), .d_in(d_in), .addr(addr), .busy(busy), .ea_valid(ea_valid),
    .ea(ea), .page_cross(page_cross), .op_len(op_len)
  );

  addr_mode_seq #(.DATA_W(8), .ADDR_W(16), .ZP_HI(8'h01)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .mode(mode), .wr(wr), .pc(pc),
    .x(x), .y(y), .d_in(d_in1), .addr(addr1), .busy(busy1), .ea_valid(ea_valid1),
    .ea(ea1), .page_cross(page_cross1), .op_len(op_len1)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
    n_chk++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, expv, $time);
    end
  endtask

  typedef struct packed {
    logic [15:0]      ea;
    logic             pc;
    logic [1:0]       len;
    logic [3:0]       lat;
    logic [5:0][15:0] a;
  } exp_t;

  // Reference: effective address from plain 16-bit arithmetic over memory.
  function automatic exp_t predict(input logic [3:0] m, input logic [15:0] p,
                                   input logic [7:0] xi, input logic [7:0] yi,
                                   input logic w, input logic [7:0] zh);
    exp_t        e;
    logic [7:0]  op, idx, pp;
    logic [15:0] base;
    logic        fix;
    e = '0;
    e.len = 2'd1;
    op = mem[p];
    case (m)
      4'd1: begin
        e.ea = {zh, op}; e.lat = 4'd2; e.a[0] = p;
      end
      4'd2, 4'd3: begin
        idx = (m == 4'd2) ? xi : yi;
        e.ea = {zh, 8'(op + idx)}; e.lat = 4'd3;
        e.a[0] = p; e.a[1] = {zh, op};
      end
      4'd4, 4'd5, 4'd6: begin
        base = {mem[16'(p + 1)], op};
        idx = (m == 4'd5) ? xi : (m == 4'd6) ? yi : 8'h00;
        e.ea = base + 16'(idx);
        e.len = 2'd2;
        e.a[0] = p; e.a[1] = 16'(p + 1);
        e.lat = 4'd3;
        if (m != 4'd4) begin
          e.pc = (e.ea[15:8] != base[15:8]);
          fix = e.pc || w;
          e.lat = fix ? 4'd4 : 4'd3;
`ifdef ADDR_MODE_SEQ_DUMMY_READ_EN
          e.a[2] = {base[15:8], e.ea[7:0]};
`else
          e.a[2] = 16'(p + 1);
`endif
        end
      end
      4'd7: begin
        pp = op + xi;
        e.ea = {mem[{zh, 8'(pp + 1)}], mem[{zh, pp}]};
        e.lat = 4'd4;
        e.a[0] = p; e.a[1] = {zh, pp}; e.a[2] = {zh, 8'(pp + 1)};
      end
      4'd8: begin
        base = {mem[{zh, 8'(op + 1)}], mem[{zh, op}]};
        e.ea = base + 16'(yi);
        e.pc = (e.ea[15:8] != base[15:8]);
        fix = e.pc || w;
        e.lat = fix ? 4'd5 : 4'd4;
        e.a[0] = p; e.a[1] = {zh, op}; e.a[2] = {zh, 8'(op + 1)};
`ifdef ADDR_MODE_SEQ_DUMMY_READ_EN
        e.a[3] = {base[15:8], e.ea[7:0]};
`else
        e.a[3] = {zh, 8'(op + 1)};
`endif
      end
      default: begin
        e.ea = p; e.lat = 4'd1;
      end
    endcase
    return e;
  endfunction

  exp_t        cur;
  bit          act = 1'b0, done = 1'b0, have_last = 1'b0;
  int          k = 0;
  logic [15:0] last_ea = '0;
  logic        last_pc = 1'b0;
  logic [1:0]  last_len = '0;
  logic [15:0] cap_ea;
  logic        cap_pc;
  int          cap_lat;

  always @(negedge clk) begin
    if (act) begin
      k++;
      chk("busy", busy, 1);
      chk("ea_valid", ea_valid, k == int'(cur.lat));
      if (k < int'(cur.lat)) chk("addr", addr, cur.a[k-1]);
      if (ea_valid && cap_lat == 0) begin
        cap_lat = k; cap_ea = ea; cap_pc = page_cross;
      end
      if (k == int'(cur.lat)) begin
        chk("ea", ea, cur.ea);
        chk("page_cross", page_cross, cur.pc);
        chk("op_len", op_len, cur.len);
        last_ea = cur.ea; last_pc = cur.pc; last_len = cur.len;
        have_last = 1'b1;
        act = 1'b0;
        done = 1'b1;
      end
    end else if (have_last) begin
      chk("idle_busy", busy, 0);
      chk("idle_ea_valid", ea_valid, 0);
      chk("idle_ea_hold", ea, last_ea);
      chk("idle_pc_hold", page_cross, last_pc);
      chk("idle_len_hold", op_len, last_len);
    end
  end

  task automatic launch(input logic [3:0] m, input logic [15:0] p, input logic [7:0] xi,
                        input logic [7:0] yi, input logic w);
    @(negedge clk); #1;
    mode = m; pc = p; x = xi; y = yi; wr = w; start = 1'b1;
    cur = predict(m, p, xi, yi, w, 8'h00);
    cap_lat = 0; done = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    pc = ~p; x = ~xi; y = ~yi; wr = ~w; mode = 4'd4;
    act = 1'b1; k = 0;
  endtask

  task automatic run(input logic [3:0] m, input logic [15:0] p, input logic [7:0] xi,
                     input logic [7:0] yi, input logic w, input bit poke);
    int t;
    launch(m, p, xi, yi, w);
    if (poke) begin
      @(negedge clk); #1;
      start = 1'b1; mode = 4'd0;
      @(posedge clk); #1;
      start = 1'b0;
    end
    t = 0;
    while (!done && t < 40) begin
      @(posedge clk);
      t++;
    end
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL timeout: sequence did not finish within %0d cycles", t);
      act = 1'b0;
    end
  endtask

  task automatic lit(input string nm, input logic [15:0] e, input logic p, input int l);
    chk({nm, "_ea"}, cap_ea, e);
    chk({nm, "_page_cross"}, cap_pc, p);
    chk({nm, "_latency"}, cap_lat, l);
  endtask

  initial begin
    int cnt;
    rst = 1'b1; start = 1'b0; start1 = 1'b0; mode = '0; pc = '0;
    x = '0; y = '0; wr = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 37 + 11);
    mem[16'h0300] = 8'hF0; mem[16'h0301] = 8'h12;
    mem[16'h0400] = 8'hFE; mem[16'h00FF] = 8'h34; mem[16'h0000] = 8'h12;
    mem[16'h0500] = 8'hF0; mem[16'h0600] = 8'h42; mem[16'h0610] = 8'hF0;
    mem[16'h0620] = 8'h34; mem[16'h0621] = 8'h12;
    mem[16'h0630] = 8'h80; mem[16'h0631] = 8'hFF;
    mem[16'h0640] = 8'h80; mem[16'h0080] = 8'h00; mem[16'h0081] = 8'h20;
    mem[16'h0650] = 8'h90; mem[16'h0090] = 8'hF8; mem[16'h0091] = 8'h20;
    mem[16'h0660] = 8'hFF; mem[16'hFFFF] = 8'h78;

    repeat (2) @(negedge clk);
    chk("rst_addr", addr, 0);      chk("rst_busy", busy, 0);
    chk("rst_ea_valid", ea_valid, 0); chk("rst_ea", ea, 0);
    chk("rst_page_cross", page_cross, 0); chk("rst_op_len", op_len, 0);
    chk("rst1_busy", busy1, 0);    chk("rst1_ea", ea1, 0);
    #1 rst = 1'b0;

    run(4'd0, 16'h0200, 8'h00, 8'h00, 1'b0, 1'b0); lit("imm", 16'h0200, 1'b0, 1);
    run(4'd5, 16'h0300, 8'h20, 8'h00, 1'b0, 1'b1); lit("absx_cross", 16'h1310, 1'b1, 4);
    run(4'd5, 16'h0300, 8'h05, 8'h00, 1'b0, 1'b0); lit("absx_nocross", 16'h12F5, 1'b0, 3);
    run(4'd6, 16'h0300, 8'h00, 8'h05, 1'b1, 1'b0); lit("absy_store", 16'h12F5, 1'b0, 4);
    run(4'd7, 16'h0400, 8'h01, 8'h00, 1'b0, 1'b1); lit("inx_wrap", 16'h1234, 1'b0, 4);
    run(4'd2, 16'h0500, 8'h20, 8'h00, 1'b0, 1'b0); lit("zpx_page", 16'h0010, 1'b0, 3);
    run(4'd1, 16'h0600, 8'h00, 8'h00, 1'b0, 1'b0);
    run(4'd3, 16'h0610, 8'h00, 8'h30, 1'b0, 1'b0);
    run(4'd4, 16'h0620, 8'h00, 8'h00, 1'b0, 1'b0);
    run(4'd6, 16'h0630, 8'h00, 8'h90, 1'b0, 1'b0); lit("absy_hi_wrap", 16'h0010, 1'b1, 4);
    run(4'd8, 16'h0640, 8'h00, 8'h10, 1'b0, 1'b0);
    run(4'd8, 16'h0640, 8'h00, 8'h10, 1'b1, 1'b0);
    run(4'd8, 16'h0650, 8'h00, 8'h10, 1'b0, 1'b0); lit("iny_cross", 16'h2108, 1'b1, 5);
    run(4'd8, 16'h0660, 8'h00, 8'h01, 1'b0, 1'b0);
    run(4'hC, 16'hABCD, 8'h00, 8'h00, 1'b0, 1'b0); lit("mode_c_imm", 16'hABCD, 1'b0, 1);
    run(4'd4, 16'hFFFF, 8'h00, 8'h00, 1'b0, 1'b0); lit("abs_pc_wrap", 16'h1278, 1'b0, 3);

    // Relocated direct page on the second instance.
    @(negedge clk); #1;
    mode = 4'd2; pc = 16'h0500; x = 8'h20; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; mode = 4'd0; x = 8'h00;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!ea_valid1 && cnt < 20);
    chk("zp_hi01_latency", cnt, 3);
    chk("zp_hi01_ea", ea1, 16'h0110);
    chk("zp_hi01_page_cross", page_cross1, 0);
    chk("zp_hi01_op_len", op_len1, 1);

    // Reset while INY is in PTR_HI.
    launch(4'd8, 16'h0640, 8'h00, 8'h10, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("pre_rst_ptr_hi_addr", addr, 16'h0081);
    act = 1'b0;
    rst = 1'b1;
    last_ea = '0; last_pc = 1'b0; last_len = '0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_ea_valid", ea_valid, 0);
    chk("async_rst_addr", addr, 0);
    chk("async_rst_ea", ea, 0);
    chk("async_rst_page_cross", page_cross, 0);
    chk("async_rst_op_len", op_len, 0);
    @(negedge clk); #1;
    rst = 1'b0;
    run(4'd0, 16'h0200, 8'h00, 8'h00, 1'b0, 1'b0); lit("imm_after_rst", 16'h0200, 1'b0, 1);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/addr_mode_seq.md
Name: addr_mode_seq

Overview:
- Parametrised addressing-mode sequencer for the 6502-class core. It replaces the fixed two-mode operand fetch (immediate, absolute) with a generalised FSM covering all nine standard modes.
- Given a mode, operand PC and X/Y, it issues operand and pointer bus reads and delivers a final effective address (EA).
- Reports page-cross and operand byte count.
- Sits between the decode FSM and the bus address mux; the ALU/register datapath consumes ea.

Parameters:
- DATA_W, 8, data/index width; ADDR_W must equal 2*DATA_W.
- ADDR_W, 16, address width.
- ZP_HI, 8'h00, high byte of the "zero page" (relocatable direct page); DATA_W bits.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin sequence; sampled only in IDLE
- mode  in  4  0 IMM, 1 ZP, 2 ZPX, 3 ZPY, 4 ABS, 5 ABSX, 6 ABSY, 7 INX, 8 INY; 9-15 treated as IMM
- wr  in  1  store instruction; forces the FIX cycle on ABSX/ABSY/INY
- pc  in  ADDR_W  address of first operand byte, sampled with start
- x, y  in  DATA_W  index registers, sampled with start
- d_in  in  DATA_W  read data for the current addr; sampled on the next rising edge
- addr  out  ADDR_W  registered bus address while busy
- busy  out  1  high in every state except IDLE
- ea_valid  out  1  one-cycle pulse (DONE state)
- ea  out  ADDR_W  effective address; valid when ea_valid, held afterwards
- page_cross  out  1  indexed add carried out of the low byte; valid with ea_valid
- op_len  out  2  operand bytes consumed (IMM/ZP*/IN* = 1, ABS* = 2); valid with ea_valid

Behaviour:
- Reset (async, any state): state=IDLE; addr, ea, op_len = 0; busy, ea_valid, page_cross = 0; internal lo/hi/ptr regs = 0.
- Start is accepted in IDLE only and ignored while busy. On acceptance pc/x/y/mode/wr are latched.
- States: IDLE, OP1, OP2, IDX, PTR_LO, PTR_HI, FIX, DONE. DONE always returns to IDLE after one cycle.
- Latency is counted from the accepting edge to the edge that enters DONE:
  - IMM: IDLE->DONE, ea=pc, 1 cycle.
  - ZP: OP1 (addr=pc) -> DONE, ea={ZP_HI,lo}, 2.
  - ZPX/ZPY: OP1 -> IDX (addr={ZP_HI,lo}, dummy read) -> DONE, ea={ZP_HI,(lo+idx) mod 2^DATA_W}. Never leaves the page. page_cross=0. Latency 3.
  - ABS: OP1 (addr=pc) -> OP2 (addr=pc+1) -> DONE, ea={hi,lo}, 3.
  - ABSX/ABSY: as ABS. sum=lo+idx, carry c. If c or wr: FIX -> DONE (4), otherwise DONE (3). ea={hi+c, sum[DATA_W-1:0]}. page_cross=c. hi+c wraps modulo 2^DATA_W.
  - INX: OP1 -> PTR_LO (addr={ZP_HI,zp+x}) -> PTR_HI (addr={ZP_HI,zp+x+1}) -> DONE, 4. Pointer increments wrap within the page (zp+x=FF reads hi from {ZP_HI,00}).
  - INY: OP1 -> PTR_LO (addr={ZP_HI,zp}) -> PTR_HI (addr={ZP_HI,zp+1}, page-wrapped) -> [FIX if carry or wr] -> DONE, 4/5. Index/carry rule as ABSY.
- pc+1 wraps at 2^ADDR_W.
- addr holds its last value in IDLE/DONE.

Optional Feature:
- Macro ADDR_MODE_SEQ_DUMMY_READ_EN.
- Defined: in FIX, addr={hi, sum[DATA_W-1:0]} (uncorrected address, 6502 dummy read).
- Undefined: addr holds the PTR_HI/OP2 value during FIX.
- Cycle counts are identical in both builds.

Decomposition:
- Shared package cpu_pkg: addressing mode enum (am_mode_t), sequencer state enum, mode encodings.
- Combinational index add is a natural sub-module: idx_add (low byte + index -> sum, carry; high byte + carry).

Test Plan:
- IMM, pc=16'h0200, start -> ea_valid 1 cycle later, ea=0200, op_len=1, no bus read.
- ABSX, pc=0300, mem[0300]=F0, mem[0301]=12, x=20, wr=0 -> FIX taken, ea_valid at cycle 4, ea=1310, page_cross=1. Repeat with x=05 -> cycle 3, ea=12F5, page_cross=0.
- ABSY, same operands, y=05, wr=1 -> FIX forced, cycle 4, ea=12F5, page_cross=0.
- INX, zp=FE, x=01, mem[00FF]=34, mem[0000]=12 -> ea=1234 at cycle 4 (pointer page wrap).
- ZPX, lo=F0, x=20, ZP_HI=00 -> ea=0010. Rebuild with ZP_HI=01 -> ea=0110. page_cross=0.
- Assert rst in PTR_HI of INY -> immediate IDLE, all outputs 0. Next start (IMM) completes normally. start while busy is ignored.
